imem_prog_loader: RTL and testbench
===================================

// Module: imem_prog_loader
// PURPOSE
//  Upstream stage of the single-cycle CPU. Receives a program as a byte stream (valid/ready) and
//  writes it word-by-word into instruction memory. Holds the CPU in reset until the load is complete.
//  Supports re-loading at runtime without a board reset.
// PARAMETERS
//  ADDR_W  8    instruction-memory word-address width
//  DEPTH   256  instruction-memory capacity in 32-bit words (<= 2**ADDR_W)
// PORTS
//  CLK          in   1       system clock, rising-edge
//  Reset        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: begin a new program load
//  in_data      in   8       stream byte
//  in_valid     in   1       in_data valid
//  in_ready     out  1       loader accepts a byte; a transfer occurs when in_valid & in_ready
//  imem_we      out  1       instruction-memory write strobe, 1 cycle per word
//  imem_addr    out  ADDR_W  word address of the write
//  imem_wdata   out  32      instruction word
//  cpu_run      out  1       1 = CPU released from reset; 0 = CPU held in reset
//  busy         out  1       high in LEN and LOAD
//  err          out  1       sticky length error, cleared by the next accepted start
//  words_loaded out  ADDR_W+1  count of words written in the current/last load
// BEHAVIOUR
//  Reset (async, Reset=0): state=IDLE. All outputs are 0: in_ready, imem_we, imem_addr, imem_wdata,
//   cpu_run, busy, err, words_loaded. The byte counter and the length register are also cleared.
//   A reset mid-load aborts the load: no further writes, the CPU stays held, and no start is implied.
//  Stream format (little-endian): 4 bytes of word count N, then N x 4 bytes of instruction.
//   The first byte of each group is bits [7:0].
//  FSM states: IDLE, LEN, LOAD, RUN, ERR.
//   IDLE: in_ready=0, cpu_run=0. A start pulse moves to LEN.
//   LEN: in_ready=1. Assembles 4 bytes into N. On the 4th accepted byte:
//     N==0 -> RUN.
//     N>DEPTH -> ERR, and err is set.
//     otherwise -> LOAD.
//   LOAD: in_ready=1. A byte counter (0..3) assembles each word.
//     On the 4th accepted byte, the next cycle has imem_we=1, imem_wdata=assembled word and
//     imem_addr=current word index (first word goes to address 0). Latency is exactly 1 cycle.
//     Also on that 4th byte: words_loaded increments and the word index increments.
//     After the N-th word's write strobe the FSM enters RUN. No byte is accepted past word N.
//   RUN: in_ready=0. cpu_run=1, registered; it rises in the cycle after the last imem_we.
//   ERR: in_ready=0, cpu_run=0. Nothing is written.
//  start handling:
//   Accepted in IDLE, RUN and ERR. Taking it clears err, words_loaded, the word index and the
//    byte counter, drops cpu_run the next cycle, and moves to LEN.
//   Ignored in LEN and LOAD (a load cannot be restarted except by Reset).
//  Gaps: in_valid may drop between any bytes; partial words and partial lengths are held indefinitely.
//  imem_we is never asserted outside LOAD. imem_addr and imem_wdata hold their last values when imem_we=0.
//  in_ready is a registered function of state only; it does not depend on in_valid.
// TESTING
//  1 start; stream 02 00 00 00, 13 05 10 00, B3 05 B5 00 -> imem_we at addr 0 with 00100513, then addr 1
//    with 00B505B3; cpu_run=1 one cycle after the 2nd strobe; words_loaded=2.
//  2 start; length 00 00 00 00 -> no imem_we; RUN with cpu_run=1; words_loaded=0.
//  3 DEPTH=256; length 01 01 00 00 (N=257) -> ERR, err=1, cpu_run=0, no writes; a new start clears err.
//  4 Same stream as 1 with in_valid toggling 1/0 every cycle -> identical writes and data, delayed only.
//  5 Reset pulled low after 5 bytes of scenario 1 -> all outputs 0 immediately; no imem_we afterwards;
//    IDLE until start.
//  6 start during LOAD ignored; in RUN, start -> cpu_run=0 next cycle; reload of 1 word writes addr 0.

Source files
------------

// File: rtl/imem_prog_loader.sv
// Byte-stream program loader for the instruction memory.
// Holds the CPU in reset until a complete, length-checked program has been written.
module imem_prog_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CW = ADDR_W + 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {IDLE, LEN, LOAD, RUN, ERR} state_t;

    state_t      state;
    logic [23:0] shreg;
    logic [1:0]  byte_cnt;
    logic [CW-1:0] len;

    logic        take;
    logic        last_byte;
    logic [31:0] word;

    // Bytes arrive LSB first, so each new byte lands on top of the shifter.
    assign take      = in_valid & in_ready;
    assign last_byte = take && (byte_cnt == 2'd3);
    assign word      = {in_data, shreg};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            shreg        <= '0;
            byte_cnt     <= '0;
            len          <= '0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (take) begin
                shreg    <= word[31:8];
                byte_cnt <= byte_cnt + 2'd1;
            end
            unique case (state)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        state        <= LEN;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        cpu_run      <= 1'b0;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        byte_cnt     <= '0;
                    end
                end
                LEN: begin
                    if (last_byte) begin
                        if (word == 32'd0) begin
                            state    <= RUN;
                            cpu_run  <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else if (word > DEPTH_W) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state <= LOAD;
                            len   <= word[CW-1:0];
                        end
                    end
                end
                LOAD: begin
                    // The final strobe cycle stays in LOAD with in_ready already low.
                    if (words_loaded == len) begin
                        state   <= RUN;
                        cpu_run <= 1'b1;
                        busy    <= 1'b0;
                    end else if (last_byte) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_W-1:0];
                        imem_wdata   <= word;
                        words_loaded <= words_loaded + CW'(1);
                        if (words_loaded + CW'(1) == len)
                            in_ready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed and randomized program loads against a byte-level reference model.
module tb_imem_prog_loader;

    typedef logic [7:0] bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        CLK = 1'b0;
    logic        Reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        busy;
    logic        err;
    logic [8:0]  words_loaded;

    imem_prog_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .CLK(CLK), .Reset(Reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_run(cpu_run), .busy(busy), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 CLK = ~CLK;

    logic [39:0] wq[$];
    int cyc = 0;
    int last_we = -1;
    int rise = -1;
    int bad_we = 0;
    logic prev_run = 1'b0;
    int passed = 0;
    int fails = 0;
    int total = 0;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (imem_we) begin
            wq.push_back({imem_addr, imem_wdata});
            last_we = cyc;
            if (!busy) bad_we = bad_we + 1;
        end
        if (cpu_run && !prev_run) rise = cyc;
        prev_run = cpu_run;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] le32(input bq_t b, input int o);
        return {b[o+3], b[o+2], b[o+1], b[o]};
    endfunction

    function automatic bq_t build(input logic [31:0] n, input wq_t w);
        bq_t b;
        for (int k = 0; k < 4; k++) b.push_back(8'(n >> (8 * k)));
        foreach (w[i])
            for (int k = 0; k < 4; k++) b.push_back(8'(w[i] >> (8 * k)));
        return b;
    endfunction

    task automatic pulse();
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
    endtask

    task automatic begin_load();
        wq.delete();
        rise = -1;
        last_we = -1;
        pulse();
    endtask

    // gap: 0 continuous, 1 toggling valid, 2 random valid
    task automatic send(input bq_t b, input int gap, input int from,
                        input int to);
        int idx = from;
        int g = 0;
        logic tog = 1'b1;
        while (idx < to && g < 5000) begin
            @(negedge CLK);
            g++;
            if (gap == 0 || (gap == 1 && tog) ||
                (gap == 2 && $urandom_range(0, 2) != 0)) begin
                in_valid = 1'b1;
                in_data  = b[idx];
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            tog = ~tog;
        end
        @(negedge CLK) in_valid = 1'b0;
        check("send_done", 64'(idx), 64'(to));
    endtask

    task automatic wait_done();
        int g = 0;
        while (!(cpu_run || err) && g < 3000) begin
            @(negedge CLK);
            g++;
        end
        @(negedge CLK);
        check("done_timeout", 64'(g < 3000), 64'd1);
    endtask

    task automatic check_result(input string tag, input bq_t b);
        logic [31:0] n = le32(b, 0);
        int mism = 0;
        if (n > 32'd256) begin
            check({tag, "_err"}, 64'(err), 64'd1);
            check({tag, "_run"}, 64'(cpu_run), 64'd0);
            check({tag, "_nwr"}, 64'(wq.size()), 64'd0);
        end else begin
            check({tag, "_run"}, 64'(cpu_run), 64'd1);
            check({tag, "_err"}, 64'(err), 64'd0);
            check({tag, "_wl"}, 64'(words_loaded), 64'(n));
            check({tag, "_nwr"}, 64'(wq.size()), 64'(n));
            for (int i = 0; i < wq.size() && i < int'(n); i++)
                if (wq[i] !== {8'(i), le32(b, 4 + 4 * i)}) mism++;
            check({tag, "_data"}, 64'(mism), 64'd0);
            if (n != 0)
                check({tag, "_lat"}, 64'(rise - last_we), 64'd1);
        end
    endtask

    initial begin
        bq_t s1, b;
        wq_t w;
        logic [31:0] n;
        Reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(negedge CLK);
        check("reset_outs", 64'({in_ready, imem_we, imem_addr, imem_wdata,
              cpu_run, busy, err, words_loaded}), 64'd0);
        @(negedge CLK) Reset = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_ready", 64'(in_ready), 64'd0);

        s1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
               8'hB3, 8'h05, 8'hB5, 8'h00};
        begin_load();
        check("start_ready", 64'(in_ready), 64'd1);
        send(s1, 0, 0, s1.size());
        wait_done();
        check_result("s1", s1);
        check("s1_w0", 64'(wq.size() > 0 ? wq[0] : 40'h0), 64'h00_00100513);
        check("s1_w1", 64'(wq.size() > 1 ? wq[1] : 40'h0), 64'h01_00B505B3);

        b = '{8'h00, 8'h00, 8'h00, 8'h00};
        begin_load();
        send(b, 0, 0, 4);
        wait_done();
        check_result("s2", b);

        b = '{8'h01, 8'h01, 8'h00, 8'h00};
        begin_load();
        send(b, 0, 0, 4);
        wait_done();
        check_result("s3", b);
        begin_load();
        check("s3_errclr", 64'(err), 64'd0);
        check("s3_busy", 64'(busy), 64'd1);
        send(s1, 0, 0, s1.size());
        wait_done();
        check_result("s3b", s1);

        begin_load();
        send(s1, 1, 0, s1.size());
        wait_done();
        check_result("s4", s1);

        begin_load();
        send(s1, 0, 0, 5);
        #2 Reset = 1'b0;
        #1 check("s5_outs", 64'({in_ready, imem_we, imem_addr, imem_wdata,
                 cpu_run, busy, err, words_loaded}), 64'd0);
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        repeat (10) @(negedge CLK);
        check("s5_nwr", 64'(wq.size()), 64'd0);
        check("s5_idle", 64'({cpu_run, busy, in_ready}), 64'd0);

        begin_load();
        send(s1, 0, 0, 6);
        pulse();
        check("s6_ignored", 64'({busy, in_ready}), 64'h3);
        send(s1, 0, 6, s1.size());
        wait_done();
        check_result("s6a", s1);
        begin_load();
        check("s6_drop", 64'(cpu_run), 64'd0);
        w = '{32'hDEADBEEF};
        b = build(32'd1, w);
        send(b, 2, 0, b.size());
        wait_done();
        check_result("s6b", b);

        for (int t = 0; t < 6; t++) begin
            w.delete();
            n = 32'($urandom_range(1, 6));
            for (int i = 0; i < int'(n); i++) w.push_back($urandom);
            b = build(n, w);
            begin_load();
            send(b, int'($urandom_range(0, 2)), 0, b.size());
            wait_done();
            check_result($sformatf("rnd%0d", t), b);
        end

        w.delete();
        for (int i = 0; i < 256; i++) w.push_back($urandom);
        b = build(32'd256, w);
        begin_load();
        send(b, 0, 0, b.size());
        wait_done();
        check_result("full", b);

        b = '{8'h00, 8'h00, 8'h00, 8'h01};
        begin_load();
        send(b, 0, 0, 4);
        wait_done();
        check_result("huge", b);

        check("we_outside_load", 64'(bad_we), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
